// File: rtl/queue_file_pkg.sv
// Shared sizing and encodings for the queue pointer file.
package queue_file_pkg;
  localparam int   QP_W      = 4;
  localparam int   N_TASK    = 2;
  localparam int   N_SLOT    = 2;
  localparam logic QDIR_LOAD = 1'b0;
  localparam logic QDIR_ADV  = 1'b1;
endpackage

// File: rtl/queue_file_qp_reg.sv
// Single queue-pointer register with async active-low clear and load enable.
module qp_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (ld_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/queue_file.sv
// Two-task x two-slot queue pointer file: combinational read, one write per
// non-held edge, write data either loaded or advanced from the current read.
module queue_file
  import queue_file_pkg::*;
#(
  parameter int QP_W = queue_file_pkg::QP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_ts,
  input  logic            w_ts,
  input  logic            hold,
  input  logic            ws,
  input  logic            rs,
  input  logic            q_dir,
  input  logic [QP_W-1:0] i_qp,
  output logic [QP_W-1:0] o_qp
);
  localparam int N_ENT = N_TASK * N_SLOT;

  logic [QP_W-1:0] entry_q [N_ENT];
  logic [QP_W-1:0] wdata_d;
  logic [1:0]      waddr;
  logic [1:0]      raddr;

  assign waddr = {w_ts, ws};
  assign raddr = {r_ts, rs};

  // Advance wraps naturally at QP_W bits.
  assign wdata_d = (q_dir == QDIR_ADV) ? o_qp + QP_W'(1) : i_qp;

  for (genvar t = 0; t < N_TASK; t++) begin : g_task
    for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
      localparam logic [1:0] IDX = 2'(t * N_SLOT + s);
      logic we_d;

      assign we_d = !hold && (waddr == IDX);

      qp_reg #(.W(QP_W)) u_qp_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (we_d),
        .d_i   (wdata_d),
        .q_o   (entry_q[t * N_SLOT + s])
      );
    end
  end

  assign o_qp = entry_q[raddr];
endmodule

// File: tb/tb_queue_file.sv
// Randomized and directed self-checking bench for queue_file.
module tb_queue_file;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       r_ts, w_ts, hold, ws, rs, q_dir;
  logic [3:0] i_qp;
  logic [3:0] o_qp;

  int n_err = 0;
  int n_chk = 0;
  logic [3:0] mdl [4];

  queue_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .r_ts  (r_ts),
    .w_ts  (w_ts),
    .hold  (hold),
    .ws    (ws),
    .rs    (rs),
    .q_dir (q_dir),
    .i_qp  (i_qp),
    .o_qp  (o_qp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input logic wt, input logic w, input logic rt, input logic r,
                     input logic dir, input logic h, input logic [3:0] d);
    w_ts = wt; ws = w; r_ts = rt; rs = r; q_dir = dir; hold = h; i_qp = d;
  endtask

  // One clock edge; model: entry[w_ts][ws] takes i_qp or (read entry + 1) mod 16 unless held.
  task automatic cycle(input string tag);
    int       wd;
    int       wa;
    logic     h;
    wd = q_dir ? (int'(mdl[{r_ts, rs}]) + 1) % 16 : int'(i_qp);
    wa = {w_ts, ws};
    h  = hold;
    @(posedge clk);
    if (!h) mdl[wa] = 4'(wd);
    #1;
    chk(tag, o_qp, mdl[{r_ts, rs}]);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      {r_ts, rs} = 2'(i);
      #1;
      chk(tag, o_qp, mdl[i]);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 4; i++) mdl[i] = 4'd0;
  endtask

  initial begin
    logic [3:0] snap;
    mdl_clear();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 4'd9);
    #1;
    sweep("reset");
    // reset dominates a write presented at an edge
    @(posedge clk); #1;
    chk("rst_dom", o_qp, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // load entry[0][1]=7 and read it
    drv(0, 1, 0, 1, 0, 0, 4'd7);
    cycle("load7");
    chk("load7_abs", o_qp, 4'd7);

    // advance into entry[0][0] from entry[0][1]; read stays 7
    drv(0, 0, 0, 1, 1, 0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      cycle("adv_rd");
      chk("adv_rd_abs", o_qp, 4'd7);
    end
    rs = 1'b0; #1;
    chk("adv_res", o_qp, 4'd8);

    // self-advance wrap: 14 -> 15, 0, 1
    drv(0, 1, 0, 1, 0, 0, 4'd14);
    cycle("load14");
    q_dir = 1'b1;
    cycle("wrap1"); chk("wrap15", o_qp, 4'd15);
    cycle("wrap2"); chk("wrap0",  o_qp, 4'd0);
    cycle("wrap3"); chk("wrap1",  o_qp, 4'd1);

    // hold suppresses all writes
    snap = o_qp;
    for (int k = 0; k < 4; k++) begin
      drv(1'($urandom), 1'($urandom), 0, 1, 1'($urandom), 1, 4'($urandom));
      cycle("hold");
      chk("hold_const", o_qp, snap);
    end
    sweep("hold_all");

    // cross-task independence
    drv(1, 0, 0, 0, 0, 0, 4'd5);
    cycle("wr_t1");
    drv(0, 0, 0, 0, 0, 0, 4'd3);
    cycle("wr_t0");
    hold = 1'b1;
    r_ts = 1'b1; rs = 1'b0; #1; chk("t1s0", o_qp, 4'd5);
    r_ts = 1'b0; #1;             chk("t0s0", o_qp, 4'd3);

    // async reset between edges
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("async_rst", o_qp, 4'd0);
    mdl_clear();
    sweep("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    sweep("rst_rel");

    // randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(3) == 0), 4'($urandom));
      cycle("rand");
      if ($urandom_range(39) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_rst", o_qp, 4'd0);
        mdl_clear();
        #1 rst_n = 1'b1;
      end
    end
    sweep("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/queue_file.md
QUEUE_FILE -- requirements
Module: queue_file

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 r_ts  input  1  read task selector (task 0/1).
REQ-004 w_ts  input  1  write task selector (task 0/1).
REQ-005 hold  input  1  1 = suppress all writes this cycle.
REQ-006 ws  input  1  write select: queue slot 0/1 within the write task.
REQ-007 rs  input  1  read select: queue slot 0/1 within the read task.
REQ-008 q_dir  input  1  write-data source: 0 = load i_qp, 1 = advance the read pointer.
REQ-009 i_qp  input  4  new queue pointer value.
REQ-010 o_qp  output  4  current queue pointer, the selected read entry.
REQ-011 Parameter QP_W, default 4, meaning pointer width; all pointer arithmetic is modulo 2^QP_W.

Function
REQ-012 Storage SHALL be 4 pointer registers, entry[task][slot], with task in {0,1} and slot in {0,1}.
REQ-013 o_qp SHALL equal entry[r_ts][rs] combinationally, with zero-cycle read latency.
REQ-014 Write data SHALL be i_qp when q_dir=0, and o_qp+1 mod 16 when q_dir=1 (15 wraps to 0).
REQ-015 On a rising edge with hold=0, entry[w_ts][ws] SHALL take the write data; all other entries SHALL hold.
REQ-016 On a rising edge with hold=1, no entry SHALL change.
REQ-017 No write enable exists beyond hold; a write occurs on every edge with hold=0.
REQ-018 There SHALL be no write-to-read bypass: when reading and writing the same entry in a cycle, o_qp shows the old value until the edge and the new value after it.
REQ-019 Self-advance SHALL be legal: with read entry = write entry and q_dir=1, the entry increments by 1 per non-held edge.
REQ-020 Read and write task/slot selectors SHALL be fully independent; any combination is legal.

Reset
REQ-021 rst_n=0 SHALL immediately clear all 4 entries to 0, independent of clk, and o_qp SHALL read 0.
REQ-022 Reset SHALL dominate any write in progress; the first write takes effect on the first rising edge after rst_n returns to 1.

Structure
REQ-023 A shared package SHALL hold QP_W, the task count (2), the slot count (2), and the q_dir encodings (QDIR_LOAD=0, QDIR_ADV=1).
REQ-024 One sub-module, qp_reg, SHALL be used: a QP_W-bit register with async active-low clear and load enable, instantiated 4 times.
REQ-025 The top level SHALL contain the write-address decode, the write-data mux and the read mux.

Verification
REQ-026 Reset, then i_qp=7, ws=1, w_ts=0, q_dir=0, hold=0, one edge -> entry[0][1]=7; set rs=1, r_ts=0 -> o_qp=7.
REQ-027 Continuing with ws=0, rs=1, q_dir=1 for several edges -> entry[0][0]=8 on every edge; o_qp stays 7; set rs=0 -> o_qp=8.
REQ-028 ws=rs=1, q_dir=1, starting entry=14, 3 edges -> o_qp sequence 15, 0, 1 (wrap).
REQ-029 hold=1 with any ws/q_dir/i_qp for 4 edges -> all entries unchanged; o_qp constant.
REQ-030 Write task 1 slot 0 = 5 and task 0 slot 0 = 3 -> r_ts=1, rs=0 reads 5; r_ts=0 reads 3; no cross-task corruption.
REQ-031 Assert rst_n=0 between clock edges after loading non-zero values -> o_qp=0 immediately; all entries read 0 after release.
